data_register_file: RTL and testbench
=====================================

Name: data_register_file

Overview:
- Parametrised successor to the 8-bit single-write data register store: one write port, two independent read ports.
- Registered reads with per-port valid and write-to-read bypass.
- Optional hardwired-zero entry 0.
- Self-clearing after reset through a sequential scrub state machine, so contents are deterministic before first use.
- Sits beside the datapath as the general operand/data store.

Parameters:
- DATA_WIDTH, 8, width of each entry in bits.
- ADDR_WIDTH, 8, width of all address ports.
- DEPTH, 256, number of entries; legal range 2 .. 2**ADDR_WIDTH.
- ZERO_REG, 0, when 1, entry 0 reads as zero and ignores writes.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- write_enable  input  1  write strobe.
- write_addr  input  ADDR_WIDTH  write address.
- write_data  input  DATA_WIDTH  write data.
- read_en_1  input  1  port 1 read request.
- read_addr_1  input  ADDR_WIDTH  port 1 address.
- read_data_1  output  DATA_WIDTH  port 1 registered data.
- read_valid_1  output  1  port 1 data valid, one cycle after request.
- read_en_2  input  1  port 2 read request.
- read_addr_2  input  ADDR_WIDTH  port 2 address.
- read_data_2  output  DATA_WIDTH  port 2 registered data.
- read_valid_2  output  1  port 2 data valid.
- ready  output  1  high once scrub is complete; accesses accepted only while high.

Behaviour:
- Reset: one clock, synchronous, active-low. When reset_n is sampled low:
  - state <= CLEAR, clear_ptr <= 0, ready <= 0.
  - read_data_1/2 <= 0, read_valid_1/2 <= 0.
  - Array contents are not touched by reset itself.
- CLEAR state: each edge writes 0 to entry clear_ptr, then clear_ptr += 1.
  - On the edge that clears entry DEPTH-1: state <= READY, ready <= 1.
  - ready rises exactly DEPTH edges after the first edge with reset_n high.
- During CLEAR:
  - write_enable, read_en_1 and read_en_2 are ignored.
  - read_valid_x stays 0 and read_data_x stays 0.
- READY state; the machine has no exit other than reset:
  - Write: if write_enable=1 and write_addr < DEPTH (and write_addr != 0 when ZERO_REG=1), the entry is updated at the edge.
- Read, port x:
  - If read_en_x=1 at edge N: read_data_x <= the entry at read_addr_x and read_valid_x <= 1, both visible after edge N. Latency is 1 cycle.
  - If read_en_x=0: read_valid_x <= 0 and read_data_x holds its previous value.
- Bypass: if a same-cycle write targets read_addr_x, read_data_x returns write_data (write-first). Both ports may bypass the same write simultaneously.
- Out-of-range address (>= DEPTH): writes are dropped; reads return 0 with read_valid_x = 1.
- ZERO_REG=1: a read of address 0 always returns 0, including under bypass. A write to address 0 is dropped.
- Both ports may read the same address in the same cycle; the results are identical.
- reset_n low mid-CLEAR or mid-READY: restart CLEAR from clear_ptr=0. Any in-flight read result is discarded (valid cleared).
- clear_ptr is ADDR_WIDTH bits wide. It never wraps, because the terminal compare is against DEPTH-1.

Test Plan:
- Reset scrub: DEPTH=256. Hold reset_n=0 for 2 cycles, then release, with write_enable=1 to addr 5, data 0xAA, throughout. Required: ready=0 for 255 edges and 1 after the 256th; a subsequent read of addr 5 returns 0x00.
- Basic write/read: write 0x3C to addr 0x10, then read_en_1 for addr 0x10 next cycle. Required: read_data_1=0x3C, read_valid_1=1 one cycle later. With read_en_1=0 afterwards, read_data_1 holds 0x3C and read_valid_1=0.
- Bypass on both ports: addr 0x20 holds 0x11. In the same cycle, write 0x99 to addr 0x20 with read_en_1 and read_en_2 both at addr 0x20. Required: both outputs = 0x99 next cycle.
- ZERO_REG=1: write 0xFF to addr 0, then read addr 0 on port 2. Required: 0x00. Repeat as a same-cycle write and read of addr 0: still 0x00.
- Out-of-range with DEPTH=100: write 0x55 to addr 150, then read addr 150. Required: read_data=0x00, read_valid=1, and entries 0..99 are unchanged.
- Reset mid-operation: pulse reset_n low for 1 cycle during CLEAR at clear_ptr=40, and again in READY with a read pending. Required: ready drops, the scrub restarts and takes the full DEPTH cycles, read_valid=0 after the reset edge, and all entries read 0.

Source files
------------

// File: rtl/data_register_file.sv
// data_register_file: one write port, two registered read ports, write-first
// bypass, optional hardwired-zero entry 0, and a scrub FSM that zeroes every
// entry after reset before accesses are accepted.

// Per-read-port pipeline stage: address qualification, bypass select and the
// registered data/valid pair.
module data_register_file_rd_port #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int ZERO_REG   = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  ready,
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  wr_fire,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid
);

  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
  logic                  read_valid_q, read_valid_d;
  logic                  addr_ok;
  logic                  addr_zero;

  // Extra top bit lets DEPTH == 2**ADDR_WIDTH compare without overflow.
  assign addr_ok   = {1'b0, read_addr} < (ADDR_WIDTH+1)'(DEPTH);
  assign addr_zero = (ZERO_REG != 0) && (read_addr == '0);

  // Select read result: zero for unmapped/hardwired entries, else bypass or array.
  always_comb begin
    read_valid_d = ready & read_en;
    read_data_d  = read_data_q;
    if (ready && read_en) begin
      if (!addr_ok || addr_zero)                 read_data_d = '0;
      else if (wr_fire && (wr_addr == read_addr)) read_data_d = wr_data;
      else                                        read_data_d = mem_data;
    end
  end

  // Output registers; reset discards any in-flight result.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
    end else begin
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
    end
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;

endmodule

module data_register_file #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int ZERO_REG   = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_en_1,
  input  logic [ADDR_WIDTH-1:0] read_addr_1,
  output logic [DATA_WIDTH-1:0] read_data_1,
  output logic                  read_valid_1,
  input  logic                  read_en_2,
  input  logic [ADDR_WIDTH-1:0] read_addr_2,
  output logic [DATA_WIDTH-1:0] read_data_2,
  output logic                  read_valid_2,
  output logic                  ready
);

  localparam int NUM_PORTS = 2;
  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clear_ptr_q, clear_ptr_d;
  logic                    ready_q, ready_d;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic                    mem_we;
  logic [IDX_W-1:0]        mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  logic                    wr_fire;

  logic [NUM_PORTS-1:0]                 rd_en, rd_vld;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rd_mem, rd_data;

  // Accepted write: only once ready, in range, and not the hardwired zero entry.
  assign wr_fire = ready_q && write_enable
                && ({1'b0, write_addr} < (ADDR_WIDTH+1)'(DEPTH))
                && !((ZERO_REG != 0) && (write_addr == '0));

  // Scrub walks clear_ptr to DEPTH-1 then parks in READY until the next reset.
  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    ready_d     = ready_q;
    mem_we      = 1'b0;
    mem_waddr   = write_addr[IDX_W-1:0];
    mem_wdata   = write_data;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clear_ptr_q[IDX_W-1:0];
        mem_wdata = '0;
        if (clear_ptr_q == LAST_IDX) begin
          state_d = ST_READY;
          ready_d = 1'b1;
        end else begin
          clear_ptr_d = clear_ptr_q + 1'b1;
        end
      end
      default: mem_we = wr_fire;
    endcase
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_CLEAR;
      clear_ptr_q <= '0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
      ready_q     <= ready_d;
    end
  end

  // Storage array; reset leaves contents alone, the scrub does the clearing.
  always_ff @(posedge clock) begin
    if (reset_n && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign rd_en   = {read_en_2, read_en_1};
  assign rd_addr = {read_addr_2, read_addr_1};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
    // Out-of-range addresses alias here but are masked inside the port.
    assign rd_mem[p] = mem_q[rd_addr[p][IDX_W-1:0]];

    data_register_file_rd_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH),
      .ZERO_REG   (ZERO_REG)
    ) u_rd (
      .clock      (clock),
      .reset_n    (reset_n),
      .ready      (ready_q),
      .read_en    (rd_en[p]),
      .read_addr  (rd_addr[p]),
      .mem_data   (rd_mem[p]),
      .wr_fire    (wr_fire),
      .wr_addr    (write_addr),
      .wr_data    (write_data),
      .read_data  (rd_data[p]),
      .read_valid (rd_vld[p])
    );
  end

  assign read_data_1  = rd_data[0];
  assign read_valid_1 = rd_vld[0];
  assign read_data_2  = rd_data[1];
  assign read_valid_2 = rd_vld[1];
  assign ready        = ready_q;

endmodule

// File: tb/tb_data_register_file.sv
// Bench for data_register_file: three configurations (plain 256, zero-reg 256,
// depth 100) share one stimulus stream and are each compared every cycle
// against a behavioural model of the storage, scrub timer and read ports.
module tb_data_register_file;

  localparam int N = 3;

  function automatic int dep(int k);
    return (k == 2) ? 100 : 256;
  endfunction

  function automatic bit zr(int k);
    return (k == 1);
  endfunction

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n = 1'b0;
  logic       we = 1'b0, re1 = 1'b0, re2 = 1'b0;
  logic [7:0] wa = '0, wd = '0, ra1 = '0, ra2 = '0;

  logic [7:0] rd1 [N];
  logic [7:0] rd2 [N];
  logic       rv1 [N];
  logic       rv2 [N];
  logic       rdy [N];

  data_register_file #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(256), .ZERO_REG(0)) u0 (
    .clock(clock), .reset_n(reset_n), .write_enable(we), .write_addr(wa), .write_data(wd),
    .read_en_1(re1), .read_addr_1(ra1), .read_data_1(rd1[0]), .read_valid_1(rv1[0]),
    .read_en_2(re2), .read_addr_2(ra2), .read_data_2(rd2[0]), .read_valid_2(rv2[0]),
    .ready(rdy[0]));

  data_register_file #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(256), .ZERO_REG(1)) u1 (
    .clock(clock), .reset_n(reset_n), .write_enable(we), .write_addr(wa), .write_data(wd),
    .read_en_1(re1), .read_addr_1(ra1), .read_data_1(rd1[1]), .read_valid_1(rv1[1]),
    .read_en_2(re2), .read_addr_2(ra2), .read_data_2(rd2[1]), .read_valid_2(rv2[1]),
    .ready(rdy[1]));

  data_register_file #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(100), .ZERO_REG(0)) u2 (
    .clock(clock), .reset_n(reset_n), .write_enable(we), .write_addr(wa), .write_data(wd),
    .read_en_1(re1), .read_addr_1(ra1), .read_data_1(rd1[2]), .read_valid_1(rv1[2]),
    .read_en_2(re2), .read_addr_2(ra2), .read_data_2(rd2[2]), .read_valid_2(rv2[2]),
    .ready(rdy[2]));

  // Reference model state
  logic [7:0] m_mem [N][256];
  int         m_cnt [N];
  bit         m_rdy [N];
  logic [7:0] m_d1  [N];
  logic [7:0] m_d2  [N];
  bit         m_v1  [N];
  bit         m_v2  [N];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s[u%0d] got %0h expected %0h at %0t", tag, k, obs, exp, $time);
    end
  endtask

  // What a read of address a returns this cycle (uses the current write inputs).
  function automatic logic [7:0] m_read(int k, logic [7:0] a);
    if (int'(a) >= dep(k) || (zr(k) && a == 8'd0)) return 8'd0;
    if (we && wa == a) return wd;
    return m_mem[k][a];
  endfunction

  task automatic model_edge();
    for (int k = 0; k < N; k++) begin
      if (!reset_n) begin
        m_cnt[k] = 0; m_rdy[k] = 0;
        m_d1[k] = 0; m_d2[k] = 0; m_v1[k] = 0; m_v2[k] = 0;
      end else if (!m_rdy[k]) begin
        m_mem[k][m_cnt[k]] = 8'd0;
        m_cnt[k]++;
        if (m_cnt[k] == dep(k)) m_rdy[k] = 1;
        m_v1[k] = 0; m_v2[k] = 0;
      end else begin
        m_v1[k] = re1; m_v2[k] = re2;
        if (re1) m_d1[k] = m_read(k, ra1);
        if (re2) m_d2[k] = m_read(k, ra2);
        if (we && int'(wa) < dep(k) && !(zr(k) && wa == 8'd0)) m_mem[k][wa] = wd;
      end
    end
  endtask

  // Advance one edge, update the model, then compare every output shortly after.
  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    for (int k = 0; k < N; k++) begin
      chk("ready", k, 32'(rdy[k]), 32'(m_rdy[k]));
      chk("valid1", k, 32'(rv1[k]), 32'(m_v1[k]));
      chk("valid2", k, 32'(rv2[k]), 32'(m_v2[k]));
      chk("data1", k, 32'(rd1[k]), 32'(m_d1[k]));
      chk("data2", k, 32'(rd2[k]), 32'(m_d2[k]));
    end
  endtask

  task automatic idle();
    we = 0; re1 = 0; re2 = 0;
  endtask

  initial begin
    int cnt;
    for (int k = 0; k < N; k++) begin
      m_cnt[k] = 0; m_rdy[k] = 0; m_d1[k] = 0; m_d2[k] = 0; m_v1[k] = 0; m_v2[k] = 0;
      for (int a = 0; a < 256; a++) m_mem[k][a] = 8'd0;
    end

    // Scrub with a write held active throughout reset and scrub
    reset_n = 0; we = 1; wa = 8'd5; wd = 8'hAA;
    #1;
    step(); step();
    reset_n = 1;
    for (int i = 1; i <= 256; i++) begin
      step();
      if (i == 255) chk("rdy_after_255", 0, 32'(rdy[0]), 32'd0);
      if (i == 256) chk("rdy_after_256", 0, 32'(rdy[0]), 32'd1);
      if (i == 100) chk("rdy_d100", 2, 32'(rdy[2]), 32'd1);
    end
    we = 0; re1 = 1; ra1 = 8'd5;
    step();
    chk("scrub_a5", 0, 32'(rd1[0]), 32'h00);
    chk("scrub_a5_v", 0, 32'(rv1[0]), 32'd1);

    // Basic write then read, then hold
    idle(); we = 1; wa = 8'h10; wd = 8'h3C;
    step();
    idle(); re1 = 1; ra1 = 8'h10;
    step();
    chk("basic_rd", 0, 32'(rd1[0]), 32'h3C);
    chk("basic_v", 0, 32'(rv1[0]), 32'd1);
    idle();
    step();
    chk("basic_hold", 0, 32'(rd1[0]), 32'h3C);
    chk("basic_v0", 0, 32'(rv1[0]), 32'd0);

    // Dual-port bypass of the same write
    idle(); we = 1; wa = 8'h20; wd = 8'h11;
    step();
    wd = 8'h99; re1 = 1; re2 = 1; ra1 = 8'h20; ra2 = 8'h20;
    step();
    chk("byp_p1", 0, 32'(rd1[0]), 32'h99);
    chk("byp_p2", 0, 32'(rd2[0]), 32'h99);
    chk("byp_p1_d100", 2, 32'(rd1[2]), 32'h99);

    // Hardwired zero entry, sequential and same-cycle
    idle(); we = 1; wa = 8'h00; wd = 8'hFF;
    step();
    idle(); re2 = 1; ra2 = 8'h00;
    step();
    chk("zr_rd", 1, 32'(rd2[1]), 32'h00);
    chk("zr_v", 1, 32'(rv2[1]), 32'd1);
    chk("nozr_rd", 0, 32'(rd2[0]), 32'hFF);
    we = 1; wa = 8'h00; wd = 8'hFF; re2 = 1; ra2 = 8'h00;
    step();
    chk("zr_byp", 1, 32'(rd2[1]), 32'h00);
    chk("nozr_byp", 0, 32'(rd2[0]), 32'hFF);

    // Out-of-range on the depth-100 instance, then sweep its entries
    idle(); we = 1; wa = 8'd150; wd = 8'h55;
    step();
    idle(); re1 = 1; ra1 = 8'd150;
    step();
    chk("oor_rd", 2, 32'(rd1[2]), 32'h00);
    chk("oor_v", 2, 32'(rv1[2]), 32'd1);
    chk("inr_rd", 0, 32'(rd1[0]), 32'h55);
    for (int a = 0; a < 100; a++) begin
      re1 = 1; ra1 = 8'(a);
      step();
    end

    // Reset pulse mid-scrub at clear_ptr 40
    idle(); reset_n = 0;
    step();
    reset_n = 1;
    repeat (40) step();
    reset_n = 0;
    step();
    chk("mid_rst_rdy", 0, 32'(rdy[0]), 32'd0);
    reset_n = 1;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      cnt++;
      if (rdy[0]) break;
    end
    chk("restart_len", 0, 32'(cnt), 32'd256);

    // Reset in READY with reads pending
    we = 1; wa = 8'h30; wd = 8'h77;
    step();
    idle(); re1 = 1; ra1 = 8'h30; re2 = 1; ra2 = 8'h10; reset_n = 0;
    step();
    chk("rst_v1", 0, 32'(rv1[0]), 32'd0);
    chk("rst_v2", 0, 32'(rv2[0]), 32'd0);
    chk("rst_rdy", 0, 32'(rdy[0]), 32'd0);
    idle(); reset_n = 1;
    repeat (256) step();
    for (int a = 0; a < 256; a++) begin
      re1 = 1; ra1 = 8'(a); re2 = 1; ra2 = 8'(255 - a);
      step();
      if (a == 8'h30 || a == 8'h10) chk("post_rst_zero", 0, 32'(rd1[0]), 32'h00);
    end

    // Randomized traffic with occasional reset
    for (int i = 0; i < 1500; i++) begin
      reset_n = ($urandom_range(0, 299) != 0);
      we  = 1'($urandom_range(0, 1));
      re1 = 1'($urandom_range(0, 1));
      re2 = 1'($urandom_range(0, 1));
      wa  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      ra1 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      ra2 = ($urandom_range(0, 2) == 0) ? ra1 : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) ra1 = wa;
      wd  = 8'($urandom_range(0, 255));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
